// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: collects WIDTH strobed bits in a per-frame bit
// order and presents the word with a valid pulse and a pending/ack handshake.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             start,
    input  logic             msb_first,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             pending,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ord_q, ord_d;
    logic             dout_valid_q, dout_valid_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic             order;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        dout_d       = dout_q;
        cnt_d        = cnt_q;
        ord_d        = ord_q;
        dout_valid_d = 1'b0;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;

        // A start restarts from an empty register with the freshly sampled order,
        // so a bit arriving alongside it shifts into a cleared frame.
        order   = start ? msb_first : ord_q;
        base    = start ? '0 : sr_q;
        shifted = order ? {base[WIDTH-2:0], serial_in} : {serial_in, base[WIDTH-1:1]};

        if (cl) begin
            state_d   = IDLE;
            sr_d      = '0;
            dout_d    = '0;
            cnt_d     = '0;
            ord_d     = 1'b0;
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (start) begin
                state_d = SHIFT;
                ord_d   = msb_first;
                sr_d    = bit_valid ? shifted : '0;
                cnt_d   = bit_valid ? CW'(1) : '0;
            end else if (state_q == SHIFT && bit_valid) begin
                sr_d = shifted;
                if (cnt_q == LAST) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            if (ack) begin
                pending_d = 1'b0;
            end
            // A completion wins over a same-cycle ack, which in turn suppresses overrun.
            if (complete) begin
                dout_d       = shifted;
                dout_valid_d = 1'b1;
                pending_d    = 1'b1;
                if (pending_q && !ack) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            dout_q       <= '0;
            cnt_q        <= '0;
            ord_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            cnt_q        <= cnt_d;
            ord_q        <= ord_d;
            dout_valid_q <= dout_valid_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign pending    = pending_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: a bit-queue model of frames checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shift_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cl = 1'b0;
    logic         start = 1'b0;
    logic         msb_first = 1'b0;
    logic         bit_valid = 1'b0;
    logic         serial_in = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         pending;
    logic         busy;
    logic         overrun;

    int n_pass = 0;
    int n_total = 0;
    int dv_seen = 0;

    // Model state: received bits of the open frame, plus the consumer-side view.
    bit           q[$];
    logic         m_active = 1'b0;
    logic         m_msb = 1'b0;
    logic         m_dv = 1'b0;
    logic         m_pend = 1'b0;
    logic         m_ovr = 1'b0;
    logic [W-1:0] m_dout = '0;

    always #5 clk = ~clk;

    shift_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cl        (cl),
        .start     (start),
        .msb_first (msb_first),
        .bit_valid (bit_valid),
        .serial_in (serial_in),
        .ack       (ack),
        .dout      (dout),
        .dout_valid(dout_valid),
        .pending   (pending),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        logic [W-1:0] word;
        logic         done;
        done = 1'b0;
        word = '0;
        if (!rst_n || cl) begin
            q.delete();
            m_active = 1'b0;
            m_msb    = 1'b0;
            m_dv     = 1'b0;
            m_pend   = 1'b0;
            m_ovr    = 1'b0;
            m_dout   = '0;
        end else begin
            m_dv = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_msb    = msb_first;
                q.delete();
                if (bit_valid) q.push_back(serial_in);
            end else if (m_active && bit_valid) begin
                q.push_back(serial_in);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        if (m_msb) word[W-1-i] = q[i];
                        else       word[i]     = q[i];
                    end
                    done     = 1'b1;
                    m_active = 1'b0;
                    q.delete();
                end
            end
            if (done) begin
                if (m_pend && !ack) m_ovr = 1'b1;
                m_pend = 1'b1;
                m_dout = word;
                m_dv   = 1'b1;
            end else if (ack) begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_dv);
        chk("pending", pending, m_pend);
        chk("busy", busy, m_active);
        chk("overrun", overrun, m_ovr);
        if (dout_valid) dv_seen++;
    endtask

    task automatic cyc(input logic st, input logic ms, input logic bv, input logic si, input logic ak);
        start     = st;
        msb_first = ms;
        bit_valid = bv;
        serial_in = si;
        ack       = ak;
        tick();
    endtask

    // seq is sent seq[W-1] first; the start cycle optionally carries the first bit.
    task automatic send_frame(input logic [W-1:0] seq, input logic ms, input int gap,
                              input logic bit_with_start, input logic ack_last);
        int first;
        first = 0;
        if (bit_with_start) begin
            cyc(1'b1, ms, 1'b1, seq[W-1], 1'b0);
            first = 1;
        end else begin
            cyc(1'b1, ms, 1'b0, 1'b0, 1'b0);
        end
        for (int i = first; i < W; i++) begin
            if (i > first) begin
                for (int g = 0; g < gap; g++) cyc(1'b0, ~ms, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            cyc(1'b0, ~ms, 1'b1, seq[W-1-i], (i == W-1) ? ack_last : 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] s;

        cyc(0, 0, 0, 0, 0);
        chk("reset dout", dout, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 1, 0);
        chk("idle bit ignored busy", busy, 0);

        // MSB-first word
        send_frame(8'hC1, 1'b1, 0, 1'b1, 1'b0);
        chk("msb dout", dout, 8'hC1);
        chk("msb dv", dout_valid, 1);
        chk("msb pending", pending, 1);
        chk("msb busy", busy, 0);
        cyc(0, 0, 0, 0, 0);
        chk("msb dv one cycle", dout_valid, 0);

        // LSB-first word
        cyc(0, 0, 0, 0, 1);
        send_frame(8'hC1, 1'b0, 0, 1'b0, 1'b0);
        chk("lsb dout", dout, 8'h83);
        chk("lsb overrun", overrun, 0);

        // Gapped strobes, then ack
        cyc(0, 0, 0, 0, 1);
        send_frame(8'hA5, 1'b1, 3, 1'b0, 1'b0);
        chk("gap dout", dout, 8'hA5);
        chk("gap pending", pending, 1);
        cyc(0, 0, 0, 0, 1);
        chk("ack clears pending", pending, 0);

        // Overrun, back-to-back frames
        send_frame(8'h12, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 0, 1'b0, 1'b0);
        chk("ovr dout", dout, 8'h34);
        chk("ovr flag", overrun, 1);
        cl = 1'b1;
        cyc(0, 0, 1, 1, 0);
        cl = 1'b0;
        chk("cl dout", dout, 0);
        chk("cl overrun", overrun, 0);
        send_frame(8'h12, 1'b1, 0, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 0, 1'b1, 1'b1);
        chk("ack@done overrun", overrun, 0);
        chk("ack@done pending", pending, 1);

        // Abort: 5 bits, then start with a bit, then 7 bits
        cyc(0, 0, 0, 0, 1);
        dv_seen = 0;
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1'($urandom_range(0, 1)), 0);
        s = 8'h9A;
        cyc(1, 1, 1, s[7], 0);
        for (int i = 6; i >= 0; i--) cyc(0, 0, 1, s[i], 0);
        cyc(0, 0, 0, 0, 0);
        chk("abort dv count", dv_seen, 1);
        chk("abort dout", dout, 8'h9A);

        // Abort exactly on the would-be last bit
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1, 0);
        s = 8'h35;
        cyc(1, 1, 1, s[7], 0);
        chk("abort last no dv", dout_valid, 0);
        chk("abort last busy", busy, 1);
        for (int i = 6; i >= 0; i--) cyc(0, 0, 1, s[i], 0);
        chk("abort last dout", dout, 8'h35);

        // Reset mid-frame
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 0);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("rst dout", dout, 0);
        chk("rst busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, 0);
        chk("post rst bits ignored", busy, 0);
        send_frame(8'h5C, 1'b1, 0, 1'b0, 1'b0);
        chk("post rst dout", dout, 8'h5C);

        // Clear mid-frame
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
        cl = 1'b1;
        cyc(0, 0, 1, 1, 0);
        cl = 1'b0;
        chk("cl mid dout", dout, 0);
        chk("cl mid pending", pending, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
        chk("post cl bits ignored", busy, 0);
        send_frame(8'hE7, 1'b0, 1, 1'b1, 1'b0);
        chk("post cl dout", dout, 8'hE7);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            cl    = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0));
        end
        rst_n = 1'b1;
        cl    = 1'b0;
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
